// File: rtl/logical_tile_io_bank_ccff.sv
// logical_tile_io_bank_ccff: NUM_CH-channel IO bank, double-buffered ccff config; IO_BANK_READBACK_EN enables commit readback on the chain
module logical_tile_io_bank_ccff #(
  parameter int NUM_CH = 4
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              config_enable,
  input  logic              IO_ISOL_N,
  input  logic              ccff_head,
  output logic              ccff_tail,
  input  logic [NUM_CH-1:0] gfpga_pad_sofa_plus_io_SOC_IN,
  output logic [NUM_CH-1:0] gfpga_pad_sofa_plus_io_SOC_OUT,
  output logic [NUM_CH-1:0] gfpga_pad_sofa_plus_io_SOC_DIR,
  input  logic [NUM_CH-1:0] io_outpad,
  output logic [NUM_CH-1:0] io_inpad,
  output logic              cfg_done,
  output logic              cfg_err
);
  localparam int LEN = 2 * NUM_CH;
  localparam int CNT_W = $clog2(LEN + 2);
  localparam logic [CNT_W-1:0] CNT_LEN = CNT_W'(LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LEN + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  state_t state, state_nx;
  logic [LEN-1:0] sr, sr_nx, shadow, shadow_nx, sr_sh;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic done_nx, err_nx, iso;
  assign sr_sh = {sr[LEN-2:0], ccff_head};
  assign ccff_tail = sr[LEN-1];
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state <= IDLE;
      sr <= '0;
      shadow <= '0;
      cnt <= '0;
      cfg_done <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      state <= state_nx;
      sr <= sr_nx;
      shadow <= shadow_nx;
      cnt <= cnt_nx;
      cfg_done <= done_nx;
      cfg_err <= err_nx;
    end
  end
  always_comb begin
    state_nx = state;
    sr_nx = sr;
    shadow_nx = shadow;
    cnt_nx = cnt;
    done_nx = cfg_done;
    err_nx = cfg_err;
    case (state)
      IDLE: if (config_enable) begin
        sr_nx = sr_sh;
        cnt_nx = CNT_W'(1);
        done_nx = 1'b0;
        err_nx = 1'b0;
        state_nx = SHIFT;
      end
      SHIFT: if (config_enable) begin
        sr_nx = sr_sh;
        cnt_nx = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
      end else state_nx = COMMIT;
      COMMIT: begin
        shadow_nx = (cnt == CNT_LEN) ? sr : shadow;
        done_nx = (cnt == CNT_LEN) ? 1'b1 : cfg_done;
        err_nx = (cnt == CNT_LEN) ? cfg_err : 1'b1;
`ifdef IO_BANK_READBACK_EN
        sr_nx = (cnt == CNT_LEN) ? sr : shadow;
`else
        sr_nx = sr;
`endif
        // a session restarted during COMMIT loses that first cycle's bit
        cnt_nx = config_enable ? '0 : cnt;
        state_nx = config_enable ? SHIFT : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  assign iso = ~IO_ISOL_N | config_enable | (state != IDLE);
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic act;
    assign act = ~iso & shadow[2*k];
    assign gfpga_pad_sofa_plus_io_SOC_DIR[k] = ~(act & ~shadow[2*k+1]);
    assign gfpga_pad_sofa_plus_io_SOC_OUT[k] = act & ~shadow[2*k+1] & io_outpad[k];
    assign io_inpad[k] = act & shadow[2*k+1] & gfpga_pad_sofa_plus_io_SOC_IN[k];
  end
endmodule
